// File: rtl/err_tlm_pkg.sv
// Shared definitions for the telemetry sequencer.
//   state_e    : frame sequencer states
//   SYNC*_DEF  : default frame sync bytes
//   frame_len  : total bytes in a frame for a given counter count
package err_tlm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_SUM  = 3'd5
  } state_e;

  localparam logic [7:0] SYNC0_DEF = 8'hEB;
  localparam logic [7:0] SYNC1_DEF = 8'h90;

  // Two sync bytes, LEN, N data bytes, SUM.
  function automatic int unsigned frame_len(input int unsigned n_cnt);
    return n_cnt + 32'd4;
  endfunction

endpackage

// File: rtl/err_tlm_seq.sv
// Telemetry sequencer for the error-record counter bank.
// Snapshots all counters on a report request (optionally clearing them with a
// one-cycle pulse) and streams HDR0, HDR1, LEN, data[0..N_CNT-1], SUM over a
// valid/ready byte interface. One further request may be queued while busy.
//   clk, rst          : clock, synchronous active-high reset
//   cnt_in            : live counters, counter k at [8k+7:8k]
//   req, clr_en       : report request, clear-after-capture enable
//   cnt_clr           : one-cycle clear pulse to the counter bank
//   tx_data, tx_valid : registered frame byte and valid
//   tx_ready          : downstream accept
//   busy, req_drop    : frame in progress, discarded-request pulse
module err_tlm_seq
  import err_tlm_pkg::*;
#(
  parameter int unsigned N_CNT = 11,
  parameter logic [7:0]  HDR0  = SYNC0_DEF,
  parameter logic [7:0]  HDR1  = SYNC1_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_CNT-1:0] cnt_in,
  input  logic               req,
  input  logic               clr_en,
  output logic               cnt_clr,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               req_drop
);

  localparam int unsigned    IW       = (N_CNT > 1) ? $clog2(N_CNT) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_CNT - 1);
  localparam logic [7:0]     LEN_B    = 8'(N_CNT);

  state_e               state_q, state_d;
  logic [8*N_CNT-1:0]   snap_q, snap_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [7:0]           sum_q, sum_d;
  logic [7:0]           txd_q, txd_d;
  logic                 txv_q, txv_d;
  logic                 pend_q, pend_d;
  logic                 clr_q, clr_d;
  logic                 drop_q, drop_d;
  logic                 hs;
  logic                 snap_evt;

  // N_CNT:1 byte mux over the snapshot.
  function automatic logic [7:0] pick(input logic [8*N_CNT-1:0] v,
                                      input logic [31:0] i);
    logic [7:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_CNT; k++) begin
      if (k == i) r = v[8*k +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    txd_d    = txd_q;
    pend_d   = pend_q;
    clr_d    = 1'b0;
    drop_d   = 1'b0;

    hs       = txv_q && tx_ready;
    snap_evt = (state_q == IDLE && req) || (state_q == S_SUM && hs && pend_q);

    // A request arriving in the same cycle that consumes pending re-queues
    // instead of dropping.
    if (snap_evt) begin
      pend_d = (state_q != IDLE) && req;
    end else if (state_q != IDLE && req) begin
      if (!pend_q) pend_d = 1'b1;
      else         drop_d = 1'b1;
    end

    unique case (state_q)
      S_HDR0: if (hs) begin
        state_d = S_HDR1;
        txd_d   = HDR1;
      end
      S_HDR1: if (hs) begin
        state_d = S_LEN;
        txd_d   = LEN_B;
      end
      S_LEN: if (hs) begin
        state_d = S_DATA;
        idx_d   = '0;
        sum_d   = LEN_B;
        txd_d   = pick(snap_q, 32'd0);
      end
      // txd_q holds the data byte being accepted, so it is folded into the
      // sum on the same handshake; the final byte's sum is the SUM byte.
      S_DATA: if (hs) begin
        sum_d = sum_q + txd_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_SUM;
          txd_d   = sum_q + txd_q;
        end else begin
          idx_d = idx_q + 1'b1;
          txd_d = pick(snap_q, 32'(idx_q) + 32'd1);
        end
      end
      S_SUM: if (hs) begin
        state_d = IDLE;
        txd_d   = '0;
      end
      default: ;
    endcase

    if (snap_evt) begin
      snap_d  = cnt_in;
      state_d = S_HDR0;
      txd_d   = HDR0;
      idx_d   = '0;
      sum_d   = '0;
      clr_d   = clr_en;
    end

    txv_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      pend_q  <= 1'b0;
      clr_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      pend_q  <= pend_d;
      clr_q   <= clr_d;
      drop_q  <= drop_d;
    end
  end

  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign busy     = (state_q != IDLE);
  assign cnt_clr  = clr_q;
  assign req_drop = drop_q;

endmodule

// File: tb/tb_err_tlm_seq.sv
// Directed bench for err_tlm_seq (N_CNT=11): table of counter patterns with
// hand-computed checksums, plus back-to-back/drop and mid-frame reset sequences.
module tb_err_tlm_seq;

  localparam int N  = 11;
  localparam int W  = 8 * N;
  localparam int FL = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cnt_in;
  logic         req;
  logic         clr_en;
  logic         cnt_clr;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         req_drop;

  int checks   = 0;
  int failures = 0;

  err_tlm_seq #(.N_CNT(11), .HDR0(8'hEB), .HDR1(8'h90)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .req      (req),
    .clr_en   (clr_en),
    .cnt_clr  (cnt_clr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .req_drop (req_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic         ce;
    bit           stall;
    logic [7:0]   sum;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raise req for one cycle; returns at the negedge where HDR0 is visible.
  task automatic send_req(input logic ce);
    @(negedge clk);
    req    = 1'b1;
    clr_en = ce;
    @(negedge clk);
    req    = 1'b0;
  endtask

  // Collect one frame starting at the current negedge. r1/r2: loop cycles on
  // which req is driven high (-1 for none).
  task automatic collect(input logic [W-1:0] snap, input logic [7:0] sum,
                         input logic ce, input bit stall, input int r1,
                         input int r2, input bit scramble,
                         output int cyc, output int drops);
    logic [7:0] exp[FL];
    logic [7:0] prev_data;
    bit         prev_stall;
    int         got, clr_cnt, clr_first;
    logic       r;
    exp[0] = 8'hEB;
    exp[1] = 8'h90;
    exp[2] = 8'h0B;
    for (int k = 0; k < N; k++) exp[3+k] = snap[8*k +: 8];
    exp[FL-1] = sum;
    got = 0; cyc = 0; drops = 0; clr_cnt = 0; clr_first = 0;
    prev_stall = 0; prev_data = '0;
    if (scramble) cnt_in = ~snap;
    while (got < FL && cyc < 400) begin
      if (cnt_clr) begin
        clr_cnt++;
        if (cyc == 0) clr_first = 1;
      end
      if (req_drop) drops++;
      chk("valid_busy", {30'd0, tx_valid, busy}, 32'd3);
      if (prev_stall) chk("stall_hold", {24'd0, tx_data}, {24'd0, prev_data});
      req = (cyc == r1 || cyc == r2);
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = r;
      if (r) begin
        chk($sformatf("byte%0d", got), {24'd0, tx_data}, {24'd0, exp[got]});
        got++;
        prev_stall = 0;
      end else begin
        prev_stall = 1;
        prev_data  = tx_data;
      end
      cyc++;
      @(negedge clk);
    end
    req = 1'b0;
    tx_ready = 1'b1;
    if (got < FL) chk("frame_timeout", got, FL);
    chk("clr_count", clr_cnt, {31'd0, ce});
    if (ce) chk("clr_on_hdr0", clr_first, 1);
  endtask

  initial begin
    logic [W-1:0] inc, ff, step, zero;
    int cyc, drops;

    for (int k = 0; k < N; k++) begin
      inc[8*k +: 8]  = 8'(k + 1);
      step[8*k +: 8] = 8'(k * 16);
    end
    ff   = '1;
    zero = '0;
    tbl[0] = '{inc,  1'b0, 1'b0, 8'h4D};
    tbl[1] = '{inc,  1'b1, 1'b0, 8'h4D};
    tbl[2] = '{inc,  1'b0, 1'b1, 8'h4D};
    tbl[3] = '{ff,   1'b0, 1'b0, 8'h00};
    tbl[4] = '{step, 1'b1, 1'b1, 8'h7B};
    tbl[5] = '{zero, 1'b0, 1'b0, 8'h0B};

    rst = 1'b1; req = 1'b0; clr_en = 1'b0; tx_ready = 1'b1; cnt_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, tx_valid}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_data",  {24'd0, tx_data}, 0);
    chk("rst_clr",   {30'd0, cnt_clr, req_drop}, 0);
    rst = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_valid", {31'd0, tx_valid}, 0);
    tx_ready = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cnt_in = tbl[i].cnt;
      send_req(tbl[i].ce);
      collect(tbl[i].cnt, tbl[i].sum, tbl[i].ce, tbl[i].stall, -1, -1, 1'b1, cyc, drops);
      if (!tbl[i].stall) chk("frame_cycles", cyc, FL);
      chk("post_idle", {30'd0, tx_valid, busy}, 0);
      chk("no_drop", drops, 0);
      repeat (2) @(negedge clk);
    end

    // Back-to-back: first request queues, second is dropped.
    cnt_in = inc;
    send_req(1'b0);
    collect(inc, 8'h4D, 1'b0, 1'b0, 2, 4, 1'b0, cyc, drops);
    chk("b2b_drop", drops, 1);
    chk("b2b_nogap", {22'd0, tx_valid, busy, tx_data}, {22'd0, 2'b11, 8'hEB});
    collect(inc, 8'h4D, 1'b0, 1'b0, -1, -1, 1'b0, cyc, drops);
    chk("b2b_cycles", cyc, FL);
    chk("b2b_end_idle", {30'd0, tx_valid, busy}, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of the data phase (index 5).
    cnt_in = inc;
    send_req(1'b0);
    repeat (8) @(negedge clk);
    chk("pre_rst_byte", {24'd0, tx_data}, 32'h06);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out", {22'd0, tx_valid, busy, tx_data}, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_idle", {30'd0, tx_valid, busy}, 0);
    send_req(1'b0);
    collect(inc, 8'h4D, 1'b0, 1'b0, -1, -1, 1'b1, cyc, drops);
    chk("fresh_cycles", cyc, FL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
